// File: rtl/fp16_packer.sv
// -----------------------------------------------------------------------------
// fp16_packer
// Output stage of the SD4 MAC datapath. It takes the normalized result triple
// {sign, norm_sum, exp_final} and packs it into an IEEE-754 binary16 word.
// Overflow, underflow and contract violations are detected and recorded.
//
// Datapath: stage A (classify) -> stage B (pack) -> output FIFO.
//
// Handshake, both ends: a word moves only on a cycle where valid & ready are
// both high. A producer holds valid and the data stable until that cycle.
// in_ready depends on registered state only, so there is no path from
// out_ready to in_ready.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   input triple handshake
//   sign, norm_sum      sign and 11-bit magnitude (bit10 = hidden bit)
//   exp_final           signed biased exponent (bias 15), -64..63
//   out_valid/out_ready output handshake, out_valid = FIFO not empty
//   out_fp16            FIFO head; reads 0 while out_valid is low
//   flag_ovf/unf/inv    sticky exception flags, flag_clr clears all three
//   result_cnt          number of results written into the FIFO (wraps)
// -----------------------------------------------------------------------------
module fp16_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign,
    input  logic [10:0]       norm_sum,
    input  logic signed [6:0] exp_final,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_fp16,
    output logic              flag_ovf,
    output logic              flag_unf,
    output logic              flag_inv,
    input  logic              flag_clr,
    output logic [15:0]       result_cnt
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_INV  = 3'd1,
        CLS_OVF  = 3'd2,
        CLS_NORM = 3'd3,
        CLS_SUB  = 3'd4
    } cls_t;

    // ---------------- stage A: classify ----------------
    cls_t              in_cls;
    logic              a_valid;
    cls_t              a_cls;
    logic              a_sign;
    logic [10:0]       a_norm;
    logic signed [6:0] a_exp;

    always_comb begin
        if (norm_sum == 11'd0)          in_cls = CLS_ZERO;
        else if (!norm_sum[10])         in_cls = CLS_INV;
        else if (exp_final >= 7'sd31)   in_cls = CLS_OVF;
        else if (exp_final >= 7'sd1)    in_cls = CLS_NORM;
        else                            in_cls = CLS_SUB;
    end

    logic accept;
    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_cls   <= CLS_ZERO;
            a_sign  <= 1'b0;
            a_norm  <= 11'd0;
            a_exp   <= 7'sd0;
        end else begin
            a_valid <= accept;
            if (accept) begin
                a_cls  <= in_cls;
                a_sign <= sign;
                a_norm <= norm_sum;
                a_exp  <= exp_final;
            end
        end
    end

    // ---------------- stage B: pack ----------------
    // Denormalizing shift: sh = 1 - exp, evaluated in 8 bits so that
    // exp = -64 still gives a positive 65.
    logic signed [7:0] sub_sh;
    logic [10:0]       sub_m;
    logic [15:0]       pack_word;

    always_comb begin
        sub_sh = 8'sd1 - {a_exp[6], a_exp};
        sub_m  = (sub_sh >= 8'sd11) ? 11'd0 : (a_norm >> sub_sh[3:0]);
        case (a_cls)
            CLS_ZERO: pack_word = {a_sign, 15'h0000};
            CLS_INV:  pack_word = 16'h7E00;
            CLS_OVF:  pack_word = {a_sign, 5'h1F, 10'h000};
            CLS_NORM: pack_word = {a_sign, a_exp[4:0], a_norm[9:0]};
            CLS_SUB:  pack_word = {a_sign, 5'h00, sub_m[9:0]};
            default:  pack_word = 16'h7E00;
        endcase
    end

    logic        b_valid;
    logic [15:0] b_word;
    logic        b_ovf, b_unf, b_inv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid <= 1'b0;
            b_word  <= 16'h0000;
            b_ovf   <= 1'b0;
            b_unf   <= 1'b0;
            b_inv   <= 1'b0;
        end else begin
            b_valid <= a_valid;
            b_word  <= pack_word;
            b_ovf   <= a_valid & (a_cls == CLS_OVF);
            b_unf   <= a_valid & (a_cls == CLS_SUB);
            b_inv   <= a_valid & (a_cls == CLS_INV);
        end
    end

    // ---------------- output FIFO ----------------
    // Stage B writes without looking at fullness. The credit check on
    // in_ready reserves a slot for every word still in stage A or B.
    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;
    logic [CW:0]   occupancy;

    assign push      = b_valid;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign out_fp16  = out_valid ? mem[rd_ptr] : 16'h0000;

    assign occupancy = {{CW{1'b0}}, a_valid} + {{CW{1'b0}}, b_valid} + {1'b0, count};
    assign in_ready  = (occupancy < DEPTH_V);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= b_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            result_cnt <= 16'h0000;
            flag_ovf   <= 1'b0;
            flag_unf   <= 1'b0;
            flag_inv   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                result_cnt <= result_cnt + 16'h0001;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A set in the same cycle as flag_clr wins.
            flag_ovf <= (flag_ovf & ~flag_clr) | (push & b_ovf);
            flag_unf <= (flag_unf & ~flag_clr) | (push & b_unf);
            flag_inv <= (flag_inv & ~flag_clr) | (push & b_inv);
        end
    end

endmodule

// File: tb/tb_fp16_packer.sv
// -----------------------------------------------------------------------------
// tb_fp16_packer
// Directed bench for fp16_packer. Inputs change 2 ns after a rising edge.
// Outputs are sampled on the falling edge. A monitor compares every popped
// word against exp_q, the queue of hand-computed expected words.
// -----------------------------------------------------------------------------
module tb_fp16_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign = 1'b0;
    logic [10:0] norm_sum = 11'd0;
    logic [6:0]  exp_final = 7'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_fp16;
    logic        flag_ovf, flag_unf, flag_inv;
    logic        flag_clr = 1'b0;
    logic [15:0] result_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_cnt = 16'd0;
    logic [15:0] held;

    fp16_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign(sign), .norm_sum(norm_sum), .exp_final(exp_final),
        .out_valid(out_valid), .out_ready(out_ready), .out_fp16(out_fp16),
        .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv),
        .flag_clr(flag_clr), .result_cnt(result_cnt)
    );

    // ---------------- clock / global bound ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got timeout want completion");
        $fatal(1, "global timeout");
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check_eq("pop_expected", 16'(exp_q.size() > 0), 16'd1);
            if (exp_q.size() > 0) check_eq("pop_word", out_fp16, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Presents one triple and returns 2 ns after the edge that accepted it.
    task automatic send(input logic s, input logic [10:0] n, input int e, input logic [15:0] expv);
        bit ok = 1'b0;
        sign      = s;
        norm_sum  = n;
        exp_final = 7'(e);
        in_valid  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("accept_in_time", 16'(ok), 16'd1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        if (ok) begin
            exp_q.push_back(expv);
            exp_cnt = exp_cnt + 16'd1;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check_eq(tag, 16'(exp_q.size()), 16'd0);
        tick();
    endtask

    task automatic clear_flags();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tick(); tick();
        @(negedge clk);
        check_eq("rst_out_valid", 16'(out_valid), 16'd0);
        check_eq("rst_out_fp16", out_fp16, 16'h0000);
        check_eq("rst_cnt", result_cnt, 16'd0);
        check_eq("rst_flags", {13'd0, flag_ovf, flag_unf, flag_inv}, 16'd0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("idle_in_ready", 16'(in_ready), 16'd1);

        // 1: 1.5 arrives 2 edges after accept
        send(1'b0, 11'h600, 15, 16'h3E00);
        @(negedge clk);
        check_eq("t1_lat_a", 16'(out_valid), 16'd0);
        @(negedge clk);
        check_eq("t1_lat_b", 16'(out_valid), 16'd0);
        @(negedge clk);
        check_eq("t1_lat_valid", 16'(out_valid), 16'd1);
        check_eq("t1_word", out_fp16, 16'h3E00);
        check_eq("t1_cnt", result_cnt, 16'd1);
        tick();
        out_ready = 1'b1;
        drain("t1_drain");

        // 2: overflow, then clear
        send(1'b1, 11'h7FF, 40, 16'hFC00);
        drain("t2_drain");
        check_eq("t2_ovf_set", 16'(flag_ovf), 16'd1);
        clear_flags();
        @(negedge clk);
        check_eq("t2_ovf_clr", 16'(flag_ovf), 16'd0);
        tick();

        // 3: subnormal and flush to zero
        send(1'b0, 11'h400, 0, 16'h0200);
        send(1'b0, 11'h7FF, -12, 16'h0000);
        drain("t3_drain");
        check_eq("t3_unf", 16'(flag_unf), 16'd1);
        check_eq("t3_no_ovf", 16'(flag_ovf), 16'd0);
        clear_flags();

        // 4: contract violation, then signed zero
        send(1'b0, 11'h3FF, 5, 16'h7E00);
        drain("t4_drain_inv");
        check_eq("t4_inv", 16'(flag_inv), 16'd1);
        check_eq("t4_inv_only", {13'd0, flag_ovf, flag_unf, flag_inv}, 16'd1);
        clear_flags();
        send(1'b1, 11'h000, 7, 16'h8000);
        drain("t4_drain_zero");
        check_eq("t4_zero_noflag", {13'd0, flag_ovf, flag_unf, flag_inv}, 16'd0);

        // boundary exponents
        send(1'b0, 11'h7FF, 30, 16'h7BFF);
        send(1'b0, 11'h400, 31, 16'h7C00);
        send(1'b0, 11'h400, 1, 16'h0400);
        send(1'b0, 11'h7FF, -9, 16'h0001);
        send(1'b1, 11'h7FF, -64, 16'h8000);
        send(1'b0, 11'h400, 63, 16'h7C00);
        drain("edge_drain");
        check_eq("edge_cnt", result_cnt, exp_cnt);
        check_eq("edge_flags", {13'd0, flag_ovf, flag_unf, flag_inv}, 16'b110);
        clear_flags();

        // 5: back-pressure fills to exactly DEPTH
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            send(1'b0, 11'h400 | 11'(i), 15, 16'h3C00 | 16'(i));
        sign = 1'b0; norm_sum = 11'h404; exp_final = 7'd15; in_valid = 1'b1;
        tick(); tick(); tick();
        held = out_fp16;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t5_in_ready_low", 16'(in_ready), 16'd0);
            check_eq("t5_head_stable", out_fp16, 16'h3C00);
        end
        check_eq("t5_held", held, 16'h3C00);
        tick();
        out_ready = 1'b1;
        send(1'b0, 11'h404, 15, 16'h3C04);
        drain("t5_drain");
        check_eq("t5_cnt", result_cnt, exp_cnt);

        // 6: reset with three items in flight
        out_ready = 1'b0;
        send(1'b1, 11'h400, 50, 16'hFC00);
        send(1'b0, 11'h500, 16, 16'h4100);
        send(1'b0, 11'h600, 14, 16'h3A00);
        check_eq("t6_ovf_before", 16'(flag_ovf), 16'd1);
        rst = 1'b1;
        #1;
        check_eq("t6_out_valid", 16'(out_valid), 16'd0);
        check_eq("t6_out_fp16", out_fp16, 16'h0000);
        check_eq("t6_cnt", result_cnt, 16'd0);
        check_eq("t6_flags", {13'd0, flag_ovf, flag_unf, flag_inv}, 16'd0);
        exp_q.delete();
        exp_cnt = 16'd0;
        tick(); tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        send(1'b0, 11'h600, 15, 16'h3E00);
        drain("t6_after_drain");
        check_eq("t6_after_cnt", result_cnt, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
